// File: rtl/mod_multiplier_barrett_pipe.sv
// mod_multiplier_barrett_pipe: fully pipelined Barrett modular multiplier, out = (a*b) mod q
module mod_multiplier_barrett_pipe #(
    parameter int W       = 64,
    parameter int MUL_LAT = 1,
    parameter int TAG_W   = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iClr,
    input  logic             iValid,
    input  logic [TAG_W-1:0] iTag,
    input  logic [W-1:0]     iData0,
    input  logic [W-1:0]     iData1,
    input  logic [W-1:0]     iMod,
    input  logic [W:0]       iU,
    output logic             oValid,
    output logic [TAG_W-1:0] oTag,
    output logic [W-1:0]     oData,
    output logic             oRangeErr
);
    localparam int ML = MUL_LAT;

    logic             range_err;
    logic [2*W-1:0]   z_in;
    logic             v1   [ML];
    logic [TAG_W-1:0] tag1 [ML];
    logic             err1 [ML];
    logic [W-1:0]     q1   [ML];
    logic [W:0]       u1   [ML];
    logic [2*W-1:0]   z1   [ML];
    logic [2*W-1:0]   z_top;
    logic [W:0]       m1;
    logic [W:0]       m3_in;
    logic             v2   [ML];
    logic [TAG_W-1:0] tag2 [ML];
    logic             err2 [ML];
    logic [W-1:0]     q2   [ML];
    logic [W+1:0]     zl2  [ML];
    logic [W:0]       m3   [ML];
    logic [W+1:0]     p_in;
    logic             v3   [ML];
    logic [TAG_W-1:0] tag3 [ML];
    logic             err3 [ML];
    logic [W-1:0]     q3   [ML];
    logic [W+1:0]     zl3  [ML];
    logic [W+1:0]     p3   [ML];
    logic [W+1:0]     t;
    logic [W+1:0]     q_x1;
    logic [W+1:0]     q_x2;
    logic [W-1:0]     res;

    assign range_err = iValid & ((iData0 >= iMod) | (iData1 >= iMod) | ~iMod[W-1]);
    assign z_in      = {{W{1'b0}}, iData0} * {{W{1'b0}}, iData1};

    // multiplier 1: z = a*b, with the operation's sideband riding alongside
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int k = 0; k < ML; k++) begin
                v1[k]   <= 1'b0;
                tag1[k] <= '0;
                err1[k] <= 1'b0;
                q1[k]   <= '0;
                u1[k]   <= '0;
                z1[k]   <= '0;
            end
        end else if (iClr) begin
            for (int k = 0; k < ML; k++) v1[k] <= 1'b0;
        end else if (iEn) begin
            v1[0]   <= iValid;
            tag1[0] <= iTag;
            err1[0] <= range_err;
            q1[0]   <= iMod;
            u1[0]   <= iU;
            z1[0]   <= z_in;
            for (int k = 1; k < ML; k++) begin
                v1[k]   <= v1[k-1];
                tag1[k] <= tag1[k-1];
                err1[k] <= err1[k-1];
                q1[k]   <= q1[k-1];
                u1[k]   <= u1[k-1];
                z1[k]   <= z1[k-1];
            end
        end
    end

    // only the upper W+1 bits of m1*U are ever needed, so keep just those
    assign z_top = z1[ML-1];
    assign m1    = z_top[2*W-1:W-1];
    assign m3_in = (W+1)'(({{(W+1){1'b0}}, m1} * {{(W+1){1'b0}}, u1[ML-1]}) >> (W+1));

    // multiplier 2: m3 = (m1*U) >> (W+1); low bits of z start their 2*MUL_LAT delay here
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int k = 0; k < ML; k++) begin
                v2[k]   <= 1'b0;
                tag2[k] <= '0;
                err2[k] <= 1'b0;
                q2[k]   <= '0;
                zl2[k]  <= '0;
                m3[k]   <= '0;
            end
        end else if (iClr) begin
            for (int k = 0; k < ML; k++) v2[k] <= 1'b0;
        end else if (iEn) begin
            v2[0]   <= v1[ML-1];
            tag2[0] <= tag1[ML-1];
            err2[0] <= err1[ML-1];
            q2[0]   <= q1[ML-1];
            zl2[0]  <= z_top[W+1:0];
            m3[0]   <= m3_in;
            for (int k = 1; k < ML; k++) begin
                v2[k]   <= v2[k-1];
                tag2[k] <= tag2[k-1];
                err2[k] <= err2[k-1];
                q2[k]   <= q2[k-1];
                zl2[k]  <= zl2[k-1];
                m3[k]   <= m3[k-1];
            end
        end
    end

    // t < 3q < 2^(W+2), so the product is only needed modulo 2^(W+2)
    assign p_in = {1'b0, m3[ML-1]} * {2'b00, q2[ML-1]};

    // multiplier 3: p = m3*q, aligned with the same operation's z
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int k = 0; k < ML; k++) begin
                v3[k]   <= 1'b0;
                tag3[k] <= '0;
                err3[k] <= 1'b0;
                q3[k]   <= '0;
                zl3[k]  <= '0;
                p3[k]   <= '0;
            end
        end else if (iClr) begin
            for (int k = 0; k < ML; k++) v3[k] <= 1'b0;
        end else if (iEn) begin
            v3[0]   <= v2[ML-1];
            tag3[0] <= tag2[ML-1];
            err3[0] <= err2[ML-1];
            q3[0]   <= q2[ML-1];
            zl3[0]  <= zl2[ML-1];
            p3[0]   <= p_in;
            for (int k = 1; k < ML; k++) begin
                v3[k]   <= v3[k-1];
                tag3[k] <= tag3[k-1];
                err3[k] <= err3[k-1];
                q3[k]   <= q3[k-1];
                zl3[k]  <= zl3[k-1];
                p3[k]   <= p3[k-1];
            end
        end
    end

    assign t    = zl3[ML-1] - p3[ML-1];
    assign q_x1 = {2'b00, q3[ML-1]};
    assign q_x2 = {1'b0, q3[ML-1], 1'b0};
    assign res  = W'(t >= q_x2 ? t - q_x2 : (t >= q_x1 ? t - q_x1 : t));

    // final correction; sideband outputs are forced to zero on bubbles
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oValid    <= 1'b0;
            oTag      <= '0;
            oData     <= '0;
            oRangeErr <= 1'b0;
        end else if (iClr) begin
            oValid    <= 1'b0;
            oTag      <= '0;
            oData     <= '0;
            oRangeErr <= 1'b0;
        end else if (iEn) begin
            oValid    <= v3[ML-1];
            oTag      <= v3[ML-1] ? tag3[ML-1] : '0;
            oData     <= v3[ML-1] ? res : '0;
            oRangeErr <= v3[ML-1] & err3[ML-1];
        end
    end
endmodule
